// File: rtl/d_scoreboard.sv
// Decode-stage register-hazard tracker: counts in-flight writers per GPR from issue to
// GRF commit and answers the two D-stage operand queries with stall/forward flags.
module d_scoreboard #(
    parameter int NREG = 32,
    parameter int TW   = 2,
    parameter int CW   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    input  logic                     issue_we_i,
    input  logic [$clog2(NREG)-1:0]  issue_wa_i,
    input  logic [TW-1:0]            issue_tnew_i,
    input  logic                     retire_we_i,
    input  logic [$clog2(NREG)-1:0]  retire_wa_i,
    input  logic [$clog2(NREG)-1:0]  a1_i,
    input  logic [$clog2(NREG)-1:0]  a2_i,
    input  logic [TW-1:0]            tuse1_i,
    input  logic [TW-1:0]            tuse2_i,
    output logic                     stall_o,
    output logic                     fwd1_o,
    output logic                     fwd2_o,
    output logic [NREG-1:0]          busy_vec_o,
    output logic                     error_o
);

    localparam int AW = $clog2(NREG);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic                      issue_acc;
    logic                      retire_acc;
    logic [NREG-1:0]           busy_vec;
    logic [NREG-1:0][TW-1:0]   tnew_vec;
    logic [NREG-1:0]           err_vec;
    logic                      error_q;
    logic                      error_d;
    logic                      fwd1;
    logic                      fwd2;
    logic                      stall;

    // Flush masks both update sources so no register sees an issue or retire that cycle.
    assign issue_acc  = issue_valid_i && issue_we_i && (issue_wa_i != '0) && !flush_i;
    assign retire_acc = retire_we_i && (retire_wa_i != '0) && !flush_i;

    assign busy_vec[0] = 1'b0;
    assign tnew_vec[0] = '0;
    assign err_vec[0]  = 1'b0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic [TW-1:0] tnew_q;
            logic [TW-1:0] tnew_d;
            logic          hit_iss;
            logic          hit_ret;
            logic          err_d;

            assign hit_iss = issue_acc && (issue_wa_i == AW'(gi));
            assign hit_ret = retire_acc && (retire_wa_i == AW'(gi));

            always_comb begin
                cnt_d  = cnt_q;
                tnew_d = tnew_q;
                err_d  = 1'b0;
                if (flush_i) begin
                    cnt_d  = '0;
                    tnew_d = '0;
                end else if (hit_iss) begin
                    tnew_d = issue_tnew_i;
                    if (hit_ret && (cnt_q != '0)) begin
                        cnt_d = cnt_q;
                    end else if (cnt_q == CNT_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        // A retire against an idle register is still a violation here.
                        cnt_d = cnt_q + 1'b1;
                        err_d = hit_ret;
                    end
                end else if (hit_ret) begin
                    if (cnt_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == CW'(1)) begin
                            tnew_d = '0;
                        end else if (tnew_q != '0) begin
                            tnew_d = tnew_q - 1'b1;
                        end
                    end
                end else if ((cnt_q != '0) && (tnew_q != '0)) begin
                    tnew_d = tnew_q - 1'b1;
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_q  <= '0;
                    tnew_q <= '0;
                end else begin
                    cnt_q  <= cnt_d;
                    tnew_q <= tnew_d;
                end
            end

            assign busy_vec[gi] = (cnt_q != '0);
            assign tnew_vec[gi] = tnew_q;
            assign err_vec[gi]  = err_d;
        end
    endgenerate

    // Queries see only registered state; a same-cycle issue shows up next cycle.
    assign fwd1  = (a1_i != '0) && busy_vec[a1_i];
    assign fwd2  = (a2_i != '0) && busy_vec[a2_i];
    assign stall = (fwd1 && (tnew_vec[a1_i] > tuse1_i)) ||
                   (fwd2 && (tnew_vec[a2_i] > tuse2_i));

    assign error_d = error_q ||
                     (!flush_i && ((|err_vec) || (issue_valid_i && stall)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign stall_o    = stall;
    assign fwd1_o     = fwd1;
    assign fwd2_o     = fwd2;
    assign busy_vec_o = busy_vec;
    assign error_o    = error_q;

endmodule

// File: tb/tb_d_scoreboard.sv
// Bench for d_scoreboard: table of per-cycle vectors, expectations queued at drive time
// and popped when outputs are sampled on the falling edge.
module tb_d_scoreboard;

    localparam int NREG = 32;
    localparam int TW   = 2;
    localparam int CW   = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              flush_i = 1'b0;
    logic              issue_valid_i = 1'b0;
    logic              issue_we_i = 1'b0;
    logic [4:0]        issue_wa_i = '0;
    logic [TW-1:0]     issue_tnew_i = '0;
    logic              retire_we_i = 1'b0;
    logic [4:0]        retire_wa_i = '0;
    logic [4:0]        a1_i = '0;
    logic [4:0]        a2_i = '0;
    logic [TW-1:0]     tuse1_i = '0;
    logic [TW-1:0]     tuse2_i = '0;
    logic              stall_o;
    logic              fwd1_o;
    logic              fwd2_o;
    logic [NREG-1:0]   busy_vec_o;
    logic              error_o;

    always #5 clk_i = ~clk_i;

    d_scoreboard #(.NREG(NREG), .TW(TW), .CW(CW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .issue_valid_i(issue_valid_i),
        .issue_we_i   (issue_we_i),
        .issue_wa_i   (issue_wa_i),
        .issue_tnew_i (issue_tnew_i),
        .retire_we_i  (retire_we_i),
        .retire_wa_i  (retire_wa_i),
        .a1_i         (a1_i),
        .a2_i         (a2_i),
        .tuse1_i      (tuse1_i),
        .tuse2_i      (tuse2_i),
        .stall_o      (stall_o),
        .fwd1_o       (fwd1_o),
        .fwd2_o       (fwd2_o),
        .busy_vec_o   (busy_vec_o),
        .error_o      (error_o)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic        iwe;
        logic [4:0]  iwa;
        logic [1:0]  itn;
        logic        rwe;
        logic [4:0]  rwa;
        logic [4:0]  a1;
        logic [1:0]  tu1;
        logic [4:0]  a2;
        logic [1:0]  tu2;
        logic        st;
        logic        f1;
        logic        f2;
        logic [31:0] busy;
        logic        err;
    } vec_t;

    typedef struct {
        int          id;
        logic        st;
        logic        f1;
        logic        f2;
        logic [31:0] busy;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_mis = 0;
    int   n_id  = 0;

    function automatic vec_t mk(logic fl, logic iv, logic iwe, logic [4:0] iwa, logic [1:0] itn,
                                logic rwe, logic [4:0] rwa, logic [4:0] a1, logic [1:0] tu1,
                                logic [4:0] a2, logic [1:0] tu2, logic st, logic f1, logic f2,
                                logic [31:0] busy, logic err);
        vec_t v;
        v.fl = fl;   v.iv = iv;   v.iwe = iwe; v.iwa = iwa; v.itn = itn;
        v.rwe = rwe; v.rwa = rwa; v.a1 = a1;   v.tu1 = tu1; v.a2 = a2; v.tu2 = tu2;
        v.st = st;   v.f1 = f1;   v.f2 = f2;   v.busy = busy; v.err = err;
        return v;
    endfunction

    task automatic push_exp(input logic st, input logic f1, input logic f2,
                            input logic [31:0] busy, input logic err);
        exp_t e;
        e.id = n_id; e.st = st; e.f1 = f1; e.f2 = f2; e.busy = busy; e.err = err;
        n_id++;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty got 0 entries want 1");
            n_mis++;
            return;
        end
        e = sb.pop_front();
        n_vec++;
        $display("vec %0d: stall=%0b fwd1=%0b fwd2=%0b busy=%08h err=%0b",
                 e.id, stall_o, fwd1_o, fwd2_o, busy_vec_o, error_o);
        if (stall_o !== e.st) begin
            $display("FAIL vec%0d stall got %0b want %0b", e.id, stall_o, e.st); n_mis++;
        end
        if (fwd1_o !== e.f1) begin
            $display("FAIL vec%0d fwd1 got %0b want %0b", e.id, fwd1_o, e.f1); n_mis++;
        end
        if (fwd2_o !== e.f2) begin
            $display("FAIL vec%0d fwd2 got %0b want %0b", e.id, fwd2_o, e.f2); n_mis++;
        end
        if (busy_vec_o !== e.busy) begin
            $display("FAIL vec%0d busy got %08h want %08h", e.id, busy_vec_o, e.busy); n_mis++;
        end
        if (error_o !== e.err) begin
            $display("FAIL vec%0d error got %0b want %0b", e.id, error_o, e.err); n_mis++;
        end
    endtask

    task automatic step(input vec_t v);
        @(posedge clk_i);
        #1;
        flush_i = v.fl;  issue_valid_i = v.iv; issue_we_i = v.iwe; issue_wa_i = v.iwa;
        issue_tnew_i = v.itn; retire_we_i = v.rwe; retire_wa_i = v.rwa;
        a1_i = v.a1; tuse1_i = v.tu1; a2_i = v.a2; tuse2_i = v.tu2;
        push_exp(v.st, v.f1, v.f2, v.busy, v.err);
        @(negedge clk_i);
        check_out();
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            fl iv we wa tn rw rwa a1 t1 a2 t2 | st f1 f2 busy          err
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 1, 8, 2, 0, 0, 5, 0, 0, 0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 1, 1, 0, 32'h100,      0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 1, 1, 0, 32'h100,      0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8, 8, 0, 0, 0, 0, 1, 0, 32'h100,      0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 1, 3, 2, 0, 0, 3, 1, 0, 0, 0, 1, 0, 32'h8,        0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 3, 1, 3, 3, 1, 1, 1, 32'h8,        0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 3, 0, 0, 0, 1, 1, 0, 32'h8,        0));
        tbl.push_back(mk(0, 1, 1, 4, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 1, 4, 3, 1, 4, 4, 1, 0, 0, 0, 1, 0, 32'h10,       0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4, 2, 0, 0, 1, 1, 0, 32'h10,       0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4, 4, 2, 0, 0, 0, 1, 0, 32'h10,       0));
        tbl.push_back(mk(0, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        1));
        // Flush with a same-cycle issue and retire: nothing survives, error is held.
        tbl.push_back(mk(0, 1, 1,10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        1));
        tbl.push_back(mk(0, 1, 1,11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h400,      1));
        tbl.push_back(mk(1, 1, 1, 6, 2, 1,10, 0, 0, 0, 0, 0, 0, 0, 32'hC00,      1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        1));
        tbl.push_back(mk(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        1));
        tbl.push_back(mk(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4,        1));
        tbl.push_back(mk(0, 1, 1,31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h84,       1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80000084, 1));

        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Asynchronous reset mid-cycle must clear state before the next edge.
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        push_exp(0, 0, 0, 32'h0, 0);
        check_out();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Counter saturates at 3 (error), then three retires drain it.
        step(mk(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  0));
        step(mk(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h20, 0));
        step(mk(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h20, 0));
        step(mk(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h20, 0));
        step(mk(0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 32'h20, 1));
        step(mk(0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 32'h20, 1));
        step(mk(0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 32'h20, 1));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  1));

        // Issue while stalled flags an error; second query port forwards.
        do_reset();
        step(mk(0, 1, 1,12, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0));
        step(mk(0, 1, 1,13, 0, 0, 0,12, 0, 0, 0, 1, 1, 0, 32'h1000, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0,13, 0,12, 3, 0, 1, 1, 32'h3000, 1));

        if (sb.size() != 0) begin
            $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
            n_mis++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
